fdiv_seq_ctrl: RTL and testbench



---
 rtl/fdiv_pkg.sv | 19 +
 rtl/fdiv_classify.sv | 48 ++++
 rtl/fdiv_seq_ctrl.sv | 94 +++++++++
 tb/tb_fdiv_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the FP32 divider sequencing controller.
package fdiv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } fdivState_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [30:0] FP32_INF  = 31'h7F800000;

    // out_flags = {inv, dz, inf_res, zero_res}
    localparam int FLAG_INV  = 3;
    localparam int FLAG_DZ   = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/fdiv_classify.sv
// Combinational FP32 special-operand classifier: flags pairs that bypass the divider
// and produces their IEEE-754 result and exception flags.
module fdiv_classify
    import fdiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        special,
    output logic [31:0] spec_s,
    output logic [3:0]  spec_flags
);

    logic aZero, bZero, aInf, bInf, aNan, bNan, sign;

    // Subnormals have exp=0 and are deliberately treated as zero.
    assign aZero = (a[30:23] == 8'h00);
    assign bZero = (b[30:23] == 8'h00);
    assign aInf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign bInf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign aNan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign bNan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign sign  = a[31] ^ b[31];

    always_comb begin
        special    = 1'b0;
        spec_s     = 32'd0;
        spec_flags = 4'd0;
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            special              = 1'b1;
            spec_s               = FP32_QNAN;
            spec_flags[FLAG_INV] = 1'b1;
        end else if (bZero) begin
            special              = 1'b1;
            spec_s               = {sign, FP32_INF};
            spec_flags[FLAG_DZ]  = 1'b1;
            spec_flags[FLAG_INF] = 1'b1;
        end else if (aInf) begin
            special              = 1'b1;
            spec_s               = {sign, FP32_INF};
            spec_flags[FLAG_INF] = 1'b1;
        end else if (aZero || bInf) begin
            special               = 1'b1;
            spec_s                = {sign, 31'd0};
            spec_flags[FLAG_ZERO] = 1'b1;
        end
    end

endmodule

// File: rtl/fdiv_seq_ctrl.sv
// Issue/collect controller around the combinational FP32 divider: holds operands for a
// settle window, then captures the quotient. FDIV_SPECIAL_EN enables the special-case bypass.
module fdiv_seq_ctrl
    import fdiv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_s,
    output logic [3:0]  out_flags
);

    fdivState_t state, nextState;
    logic [3:0]  cnt;
    logic [31:0] divA, divB, outS;
    logic [3:0]  outFlags;
    logic        accept, special;
    logic [31:0] specS;
    logic [3:0]  specFlags;

`ifdef FDIV_SPECIAL_EN
    fdiv_classify uClassify (
        .a          (in_a),
        .b          (in_b),
        .special    (special),
        .spec_s     (specS),
        .spec_flags (specFlags)
    );
`else
    assign special   = 1'b0;
    assign specS     = 32'd0;
    assign specFlags = 4'd0;
`endif

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = special ? DONE : SETTLE;
            SETTLE:  if (cnt == 4'd0) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            divA     <= 32'd0;
            divB     <= 32'd0;
            outS     <= 32'd0;
            outFlags <= 4'd0;
        end else if (accept) begin
            divA <= in_a;
            divB <= in_b;
            cnt  <= 4'(SETTLE_CYCLES - 1);
            if (special) begin
                outS     <= specS;
                outFlags <= specFlags;
            end
        end else if (state == SETTLE) begin
            if (cnt == 4'd0) begin
                outS     <= div_s;
                outFlags <= 4'd0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign div_a     = divA;
    assign div_b     = divB;
    assign out_s     = outS;
    assign out_flags = outFlags;

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Self-checking bench for fdiv_seq_ctrl: directed test-plan cases plus randomized pairs
// against an arithmetic reference of the divider and the IEEE special-case rules.
module tb_fdiv_seq_ctrl;

    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [31:0] div_a, div_b, div_s;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_s;
    logic [3:0]  out_flags;

    int passed = 0;
    int total  = 0;
    logic [31:0] lastS;

    always #5 clk = ~clk;

    fdiv_seq_ctrl #(.SETTLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_s     (div_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_flags (out_flags)
    );

    // ---------------- reference model ----------------
    function automatic bit isZero(input logic [31:0] x); return x[30:23] == 8'h00; endfunction
    function automatic bit isInf (input logic [31:0] x); return x[30:0] == 31'h7F800000; endfunction
    function automatic bit isNan (input logic [31:0] x); return x[30:23] == 8'hFF && x[22:0] != 0; endfunction

    function automatic real toReal(input logic [31:0] x);
        logic [10:0] e;
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] toFp32(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // 4'b{inv,dz,inf,zero} and result for a pair; kind 0 = ordinary finite division
    function automatic logic [35:0] refSpecial(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (isNan(a) || isNan(b) || (isZero(a) && isZero(b)) || (isInf(a) && isInf(b)))
            return {4'b1000, 32'h7FC00000};
        if (isZero(b)) return {4'b0110, s, 31'h7F800000};
        if (isInf(a))  return {4'b0010, s, 31'h7F800000};
        if (isZero(a) || isInf(b)) return {4'b0001, s, 31'd0};
        return 36'd0;
    endfunction

    function automatic logic [31:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        logic [35:0] sp;
        sp = refSpecial(a, b);
        if (sp[35:32] != 4'd0) return sp[31:0];
        return toFp32(toReal(a) / toReal(b));
    endfunction

    // Stand-in for the combinational divider datapath.
    assign div_s = refDiv(div_a, div_b);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One operation: accept, wait for result, hold off out_ready for 'hold' cycles, release.
    task automatic doOp(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [35:0] sp;
        logic [31:0] expS;
        logic [3:0]  expF;
        int expLat, lat;
        sp   = refSpecial(a, b);
        expS = refDiv(a, b);
`ifdef FDIV_SPECIAL_EN
        expF   = sp[35:32];
        expLat = (sp[35:32] != 4'd0) ? 0 : SC;
`else
        expF   = 4'd0;
        expLat = SC;
`endif
        out_ready = (hold == 0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, expLat);
        chk("out_s", out_s, expS);
        chk("out_flags", 32'(out_flags), 32'(expF));
        chk("div_a", div_a, a);
        chk("div_b", div_b, b);
        lastS = out_s;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom;
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_s", out_s, expS);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        if (hold > 0) out_ready = 1'b1;
        tick();
        chk("release_idle", 32'(in_ready), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("div_a_kept", div_a, a);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] randNormal();
        logic [7:0] e;
        e = 8'($urandom_range(154, 100));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [31:0] specTab [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                                 32'hFF800000, 32'h7FC00001, 32'h00012345};

    initial begin
        logic [31:0] ra, rb;
        int seen;
        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_s", out_s, 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // directed test-plan cases
        doOp(32'h40C00000, 32'h40000000, 0);
        chk("6div2", lastS, 32'h40400000);
        doOp(32'h3F800000, 32'h00000000, 0);
        chk("1div0", lastS, 32'h7F800000);
        doOp(32'h00000000, 32'h00000000, 0);
        chk("0div0", lastS, 32'h7FC00000);
        doOp(32'h7FC00001, 32'h3F800000, 0);
        chk("nan_div", lastS, 32'h7FC00000);
        doOp(32'hFF800000, 32'h40000000, 0);
        chk("ninf_div2", lastS, 32'hFF800000);
        doOp(32'h40000000, 32'hFF800000, 0);
        chk("2div_ninf", lastS, 32'h80000000);
        doOp(32'h40C00000, 32'h40000000, 5);

        // reset during SETTLE aborts the operation
        in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_div_a", div_a, 32'd0);
        chk("abort_s", out_s, 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        doOp(32'h40400000, 32'h3FC00000, 0);
        chk("3div1p5", lastS, 32'h40000000);

        // randomized pairs
        for (int n = 0; n < 24; n++) begin
            ra = ($urandom_range(3) == 0) ? specTab[$urandom_range(5)] : randNormal();
            rb = ($urandom_range(3) == 0) ? specTab[$urandom_range(5)] : randNormal();
            doOp(ra, rb, int'($urandom_range(3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
